// File: rtl/cp_sequencer_if.sv
// Request/grant handshake and pump-control bundle for cp_sequencer.
// master = requester/loop logic side, slave = sequencer side.
interface cp_sequencer_if #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned NET_W = 8
);
  logic             start;
  logic             stop;
  logic             up_req;
  logic [CNT_W-1:0] up_len;
  logic             up_ack;
  logic             dn_req;
  logic [CNT_W-1:0] dn_len;
  logic             dn_ack;
  logic             src_n;
  logic             snk;
  logic             preChrg;
  logic             rst;
  logic             busy;
  logic [NET_W-1:0] net;

  modport master (
    output start, stop, up_req, up_len, dn_req, dn_len,
    input  up_ack, dn_ack, src_n, snk, preChrg, rst, busy, net
  );

  modport slave (
    input  start, stop, up_req, up_len, dn_req, dn_len,
    output up_ack, dn_ack, src_n, snk, preChrg, rst, busy, net
  );
endinterface

// File: rtl/cp_sequencer.sv
// Charge-pump burst scheduler: precharge, round-robin UP/DN grants with
// dead-time gaps, and a saturating signed net-charge tally.
module cp_sequencer #(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned PRE_CYCLES  = 11,
  parameter int unsigned DEAD_CYCLES = 1,
  parameter int unsigned NET_W       = 8
) (
  input logic           clk,
  input logic           reset,
  cp_sequencer_if.slave bus
);

  // Sum width holds net +/- the largest zero-extended length without wrap.
  localparam int unsigned SUM_W = ((NET_W > CNT_W) ? NET_W : CNT_W) + 2;
  localparam logic signed [SUM_W-1:0] NET_MAX = {{(SUM_W-NET_W+1){1'b0}}, {(NET_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] NET_MIN = {{(SUM_W-NET_W+1){1'b1}}, {(NET_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, PRECHARGE, READY, SRC, SNK, DEAD
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] blen, blen_d;
  logic             last_up, last_up_d;  // 1 when the most recent grant went to UP
  logic [NET_W-1:0] net_d;
  logic             up_ack_d, dn_ack_d;
  logic signed [SUM_W-1:0] net_ext, len_ext;

  function automatic logic [NET_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > NET_MAX) return NET_W'(NET_MAX);
    if (v < NET_MIN) return NET_W'(NET_MIN);
    return NET_W'(v);
  endfunction

  // Next-state, counters, arbitration and tally update
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    blen_d    = blen;
    last_up_d = last_up;
    net_d     = bus.net;
    up_ack_d  = 1'b0;
    dn_ack_d  = 1'b0;
    net_ext   = {{(SUM_W-NET_W){bus.net[NET_W-1]}}, bus.net};
    len_ext   = {{(SUM_W-CNT_W){1'b0}}, blen};

    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_d = PRECHARGE;
            cnt_d   = CNT_W'(PRE_CYCLES);
            net_d   = '0;
          end
        end
        PRECHARGE: begin
          if (cnt == CNT_W'(1)) state_d = READY;
          else                  cnt_d   = cnt - CNT_W'(1);
        end
        READY: begin
          if (bus.up_req && (!bus.dn_req || !last_up)) begin
            last_up_d = 1'b1;
            if (bus.up_len == '0) begin
              up_ack_d = 1'b1;
            end else begin
              state_d = SRC;
              cnt_d   = bus.up_len;
              blen_d  = bus.up_len;
            end
          end else if (bus.dn_req) begin
            last_up_d = 1'b0;
            if (bus.dn_len == '0) begin
              dn_ack_d = 1'b1;
            end else begin
              state_d = SNK;
              cnt_d   = bus.dn_len;
              blen_d  = bus.dn_len;
            end
          end
        end
        SRC, SNK: begin
          if (cnt == CNT_W'(1)) begin
            state_d = DEAD;
            cnt_d   = CNT_W'(DEAD_CYCLES);
            if (state == SRC) begin
              up_ack_d = 1'b1;
              net_d    = sat(net_ext + len_ext);
            end else begin
              dn_ack_d = 1'b1;
              net_d    = sat(net_ext - len_ext);
            end
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        DEAD: begin
          if (cnt == CNT_W'(1)) state_d = READY;
          else                  cnt_d   = cnt - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; pump controls decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      blen        <= '0;
      last_up     <= 1'b0;
      bus.net     <= '0;
      bus.up_ack  <= 1'b0;
      bus.dn_ack  <= 1'b0;
      bus.src_n   <= 1'b1;
      bus.snk     <= 1'b0;
      bus.preChrg <= 1'b0;
      bus.rst     <= 1'b1;
      bus.busy    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      blen        <= blen_d;
      last_up     <= last_up_d;
      bus.net     <= net_d;
      bus.up_ack  <= up_ack_d;
      bus.dn_ack  <= dn_ack_d;
      bus.src_n   <= (state_d != SRC);
      bus.snk     <= (state_d == SNK);
      bus.preChrg <= (state_d == PRECHARGE);
      bus.rst     <= 1'b0;
      bus.busy    <= !((state_d == IDLE) || (state_d == READY));
    end
  end

endmodule

// File: tb/tb_cp_sequencer.sv
// Self-checking bench for cp_sequencer: directed scenarios plus random
// single-requester bursts against a transaction-level net-charge model.
module tb_cp_sequencer;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned NET_W = 8;
  localparam int PRE  = 11;
  localparam int DEAD = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   model_net;

  cp_sequencer_if #(.CNT_W(CNT_W), .NET_W(NET_W)) bus ();

  cp_sequencer #(
    .CNT_W(CNT_W), .PRE_CYCLES(PRE), .DEAD_CYCLES(DEAD), .NET_W(NET_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat_net(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int net_now();
    return int'($signed(bus.net));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request alone and measure the resulting burst.
  task automatic run_burst(input bit up, input int len, output int active,
                           output int acks, output int dead, output bit bad);
    active = 0; acks = 0; dead = 0; bad = 1'b0;
    if (up) begin bus.up_req = 1'b1; bus.up_len = CNT_W'(len); end
    else    begin bus.dn_req = 1'b1; bus.dn_len = CNT_W'(len); end
    for (int i = 0; i < 100 && acks == 0; i++) begin
      step();
      if (!bus.src_n && bus.snk) bad = 1'b1;
      if (up ? bus.snk : !bus.src_n) bad = 1'b1;
      if (up ? bus.dn_ack : bus.up_ack) bad = 1'b1;
      if (up ? !bus.src_n : bus.snk) active++;
      if (up ? bus.up_ack : bus.dn_ack) acks++;
    end
    bus.up_req = 1'b0;
    bus.dn_req = 1'b0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      if (!bus.src_n || bus.snk) bad = 1'b1;
      dead++;
      step();
      if (up ? bus.up_ack : bus.dn_ack) acks++;
    end
    step();
    if (up ? bus.up_ack : bus.dn_ack) acks++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 0; bus.stop = 0;
    bus.up_req = 0; bus.dn_req = 0; bus.up_len = '0; bus.dn_len = '0;
    #2;
    checks++; if (bus.src_n !== 1'b1 || bus.snk !== 1'b0 || bus.preChrg !== 1'b0) begin
      errors++; $display("FAIL reset_pump: src_n=%b snk=%b preChrg=%b expected 1 0 0", bus.src_n, bus.snk, bus.preChrg); end
    step(); step();
    reset = 1'b0;
    checks++; if (bus.rst !== 1'b1) begin errors++; $display("FAIL reset_rst_held: rst=%b expected 1", bus.rst); end
    checks++; if (bus.net !== '0 || bus.busy !== 1'b0 || bus.up_ack !== 1'b0 || bus.dn_ack !== 1'b0) begin
      errors++; $display("FAIL reset_state: net=%0d busy=%b acks=%b%b expected 0 0 00", bus.net, bus.busy, bus.up_ack, bus.dn_ack); end
    step();
    checks++; if (bus.rst !== 1'b0) begin errors++; $display("FAIL reset_rst_clear: rst=%b expected 0", bus.rst); end
    checks++; if (bus.src_n !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: src_n=%b busy=%b expected 1 0", bus.src_n, bus.busy); end
  endtask

  task automatic test_precharge();
    int n;
    n = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL pre_busy: busy=%b expected 1", bus.busy); end
    for (int i = 0; i < 40 && bus.preChrg; i++) begin n++; step(); end
    checks++; if (n != PRE) begin errors++; $display("FAIL pre_len: preChrg cycles=%0d expected %0d", n, PRE); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL pre_ready_busy: busy=%b expected 0", bus.busy); end
    model_net = 0;
  endtask

  task automatic test_up_dn();
    int a, k, d; bit b;
    run_burst(1'b1, 3, a, k, d, b);
    model_net = sat_net(model_net + 3);
    checks++; if (a != 3 || k != 1 || d != DEAD || b) begin
      errors++; $display("FAIL up3_burst: active=%0d acks=%0d dead=%0d bad=%b expected 3 1 %0d 0", a, k, d, b, DEAD); end
    checks++; if (net_now() != model_net) begin errors++; $display("FAIL up3_net: net=%0d expected %0d", net_now(), model_net); end
    run_burst(1'b0, 5, a, k, d, b);
    model_net = sat_net(model_net - 5);
    checks++; if (a != 5 || k != 1 || d != DEAD || b) begin
      errors++; $display("FAIL dn5_burst: active=%0d acks=%0d dead=%0d bad=%b expected 5 1 %0d 0", a, k, d, b, DEAD); end
    checks++; if (net_now() != -2 || model_net != -2) begin errors++; $display("FAIL dn5_net: net=%0d expected -2", net_now()); end
  endtask

  task automatic test_alternate();
    int ack_t[$];
    bit ack_up[$];
    int prev, cur, alt_bad;
    bit overlap, nogap;
    prev = 0; alt_bad = 0; overlap = 0; nogap = 0;
    bus.up_len = CNT_W'(2); bus.dn_len = CNT_W'(2);
    bus.up_req = 1'b1; bus.dn_req = 1'b1;
    for (int i = 0; i < 44; i++) begin
      if (i == 30) begin bus.up_req = 1'b0; bus.dn_req = 1'b0; end
      step();
      if (!bus.src_n && bus.snk) overlap = 1'b1;
      cur = !bus.src_n ? 1 : (bus.snk ? 2 : 0);
      if (cur != 0 && prev != 0 && cur != prev) nogap = 1'b1;
      prev = cur;
      if (bus.up_ack) begin ack_t.push_back(i); ack_up.push_back(1'b1); model_net = sat_net(model_net + 2); end
      if (bus.dn_ack) begin ack_t.push_back(i); ack_up.push_back(1'b0); model_net = sat_net(model_net - 2); end
    end
    for (int j = 1; j < ack_t.size(); j++) begin
      if (ack_up[j] == ack_up[j-1]) alt_bad++;
      if (ack_t[j] - ack_t[j-1] != 2 + DEAD + 1) alt_bad++;
    end
    checks++; if (ack_t.size() != 8) begin errors++; $display("FAIL alt_count: acks=%0d expected 8", ack_t.size()); end
    checks++; if (ack_t.size() == 0 || ack_up[0] !== 1'b1) begin errors++; $display("FAIL alt_first: first grant not UP (acks=%0d)", ack_t.size()); end
    checks++; if (alt_bad != 0) begin errors++; $display("FAIL alt_order: %0d order/spacing violations expected 0", alt_bad); end
    checks++; if (overlap || nogap) begin errors++; $display("FAIL alt_gap: overlap=%b nogap=%b expected 0 0", overlap, nogap); end
    checks++; if (net_now() != model_net || bus.busy !== 1'b0) begin
      errors++; $display("FAIL alt_net: net=%0d busy=%b expected %0d 0", net_now(), bus.busy, model_net); end
  endtask

  task automatic test_stop();
    bit saw_ack, saw_src;
    saw_ack = 0; saw_src = 0;
    bus.dn_len = CNT_W'(6); bus.dn_req = 1'b1;
    step(); step();
    checks++; if (bus.snk !== 1'b1) begin errors++; $display("FAIL stop_pre: snk=%b expected 1", bus.snk); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0; bus.dn_req = 1'b0;
    checks++; if (bus.snk !== 1'b0 || bus.src_n !== 1'b1 || bus.preChrg !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL stop_off: snk=%b src_n=%b preChrg=%b busy=%b expected 0 1 0 0", bus.snk, bus.src_n, bus.preChrg, bus.busy); end
    if (bus.dn_ack) saw_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); if (bus.dn_ack || bus.snk) saw_ack = 1'b1; end
    checks++; if (saw_ack) begin errors++; $display("FAIL stop_noack: dn_ack/snk seen after abort, expected none"); end
    checks++; if (net_now() != model_net) begin errors++; $display("FAIL stop_net: net=%0d expected %0d", net_now(), model_net); end
    bus.up_len = CNT_W'(2); bus.up_req = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); if (!bus.src_n || bus.up_ack) saw_src = 1'b1; end
    bus.up_req = 1'b0;
    checks++; if (saw_src) begin errors++; $display("FAIL stop_idle: grant issued while expected IDLE"); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    model_net = 0;
    checks++; if (net_now() != 0 || bus.preChrg !== 1'b1) begin
      errors++; $display("FAIL stop_restart: net=%0d preChrg=%b expected 0 1", net_now(), bus.preChrg); end
    for (int i = 0; i < 40 && bus.preChrg; i++) step();
  endtask

  task automatic test_saturation();
    bit up_seq[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    int len_seq[9] = '{63, 63, 63, 63, 63, 63, 63, 63, 63};
    int a, k, d; bit b; int bad_cnt;
    bad_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      run_burst(up_seq[i], len_seq[i], a, k, d, b);
      model_net = sat_net(up_seq[i] ? model_net + len_seq[i] : model_net - len_seq[i]);
      if (a != len_seq[i] || k != 1 || b) bad_cnt++;
      if (i == 3) begin
        checks++; if (net_now() != 127) begin errors++; $display("FAIL sat_pos: net=%0d expected 127", net_now()); end
        run_burst(1'b0, 0, a, k, d, b);
        checks++; if (a != 0 || k != 1 || d != 0 || b) begin
          errors++; $display("FAIL zero_len: active=%0d acks=%0d dead=%0d bad=%b expected 0 1 0 0", a, k, d, b); end
        checks++; if (net_now() != 127) begin errors++; $display("FAIL zero_net: net=%0d expected 127", net_now()); end
      end
    end
    checks++; if (bad_cnt != 0) begin errors++; $display("FAIL sat_bursts: %0d malformed bursts expected 0", bad_cnt); end
    checks++; if (net_now() != -128 || model_net != -128) begin errors++; $display("FAIL sat_neg: net=%0d expected -128", net_now()); end
  endtask

  task automatic test_random();
    int a, k, d, len; bit b, up;
    for (int i = 0; i < 24; i++) begin
      up  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63));
      run_burst(up, len, a, k, d, b);
      model_net = sat_net(up ? model_net + len : model_net - len);
      checks++; if (a != len || k != 1 || b || d != ((len == 0) ? 0 : DEAD)) begin
        errors++; $display("FAIL rand_burst[%0d]: up=%b active=%0d acks=%0d dead=%0d bad=%b expected len=%0d 1 ack", i, up, a, k, d, b, len); end
      checks++; if (net_now() != model_net) begin
        errors++; $display("FAIL rand_net[%0d]: net=%0d expected %0d", i, net_now(), model_net); end
    end
  endtask

  task automatic test_async_reset();
    bus.up_len = CNT_W'(10); bus.up_req = 1'b1;
    step(); step();
    checks++; if (bus.src_n !== 1'b0) begin errors++; $display("FAIL areset_pre: src_n=%b expected 0", bus.src_n); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.src_n !== 1'b1 || bus.rst !== 1'b1 || bus.net !== '0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL areset_now: src_n=%b rst=%b net=%0d busy=%b expected 1 1 0 0", bus.src_n, bus.rst, bus.net, bus.busy); end
    bus.up_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++; if (bus.rst !== 1'b0 || bus.src_n !== 1'b1) begin
      errors++; $display("FAIL areset_release: rst=%b src_n=%b expected 0 1", bus.rst, bus.src_n); end
  endtask

  initial begin
    checks = 0; errors = 0; model_net = 0;
    test_reset();
    test_precharge();
    test_up_dn();
    test_alternate();
    test_stop();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
